multicycle_controller: RTL and testbench

Parametrised multi-cycle successor to the single-cycle main decoder. A Moore/Mealy FSM sequences each RV32I instruction (R, I-ALU, LW, SW, B, JAL, JALR, LUI) over 3–5 cycles plus memory wait states, sharing one ALU and one memory port. It adds a variable-latency memory handshake, in-controller branch resolution, a memory timeout, an illegal-opcode policy and a retired-instruction counter. It sits between the instruction register and the multi-cycle datapath muxes and enables.

---
 rtl/ctrl_pkg.sv | 75 +++++++
 rtl/branch_cond.sv | 23 ++
 rtl/multicycle_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states, mux selects.
// Latency: none (declarations only).
// Backpressure: none.
package ctrl_pkg;

    // RV32I major opcodes handled by the controller
    localparam logic [6:0] R_T  = 7'b0110011;
    localparam logic [6:0] I_T  = 7'b0010011;
    localparam logic [6:0] S_T  = 7'b0100011;
    localparam logic [6:0] B_T  = 7'b1100011;
    localparam logic [6:0] U_T  = 7'b0110111;
    localparam logic [6:0] J_T  = 7'b1101111;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] JALR = 7'b1100111;

    // Controller states; S_ prefix keeps them apart from the opcode names
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_LUI,
        S_HALT
    } state_e;

    // ALU operand A select
    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_A     = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SB_B     = 2'b00;
    localparam logic [1:0] SB_IMM   = 2'b01;
    localparam logic [1:0] SB_FOUR  = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_BR   = 2'b01;
    localparam logic [1:0] ALU_R    = 2'b10;
    localparam logic [1:0] ALU_I    = 2'b11;

    // Immediate format select
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;

    // Result bus select
    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_DATA   = 2'b01;
    localparam logic [1:0] RS_ALU    = 2'b10;
    localparam logic [1:0] RS_IMM    = 2'b11;

    // Immediate format implied by an opcode; anything without its own format uses I
    function automatic logic [2:0] imm_of(input logic [6:0] opc);
        case (opc)
            S_T:     return IMM_S;
            B_T:     return IMM_B;
            J_T:     return IMM_J;
            U_T:     return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Resolves the RV32I branch condition from funct3 and the ALU compare flags.
// Latency: combinational.
// Backpressure: none.
module branch_cond (
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    output logic       taken_o
);

    // beq/bne use the zero flag, blt/bge the signed less-than flag; others never branch
    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            3'b000:  taken_o = zero_i;
            3'b001:  taken_o = ~zero_i;
            3'b100:  taken_o = lt_i;
            3'b101:  taken_o = ~lt_i;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM driving datapath muxes/enables, with memory timeout and instret.
// Latency: 3-5 cycles per instruction plus memory wait cycles.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until mem_ready; WAIT_MAX stalled cycles -> bus error.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX     = 16,
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_src,
    output logic [1:0]       result_src,
    output logic             illegal,
    output logic             bus_err,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    state_e           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic             taken;
    logic             op_legal;
    logic             in_mem;
    logic             timeout;
    logic             mem_req_m, mem_write_m, ir_write_m, pc_write_m, reg_write_m;

    branch_cond u_branch_cond (
        .funct3_i (funct3),
        .zero_i   (zero),
        .lt_i     (lt),
        .taken_o  (taken)
    );

    // Opcode whitelist; anything else is reported as illegal in DECODE
    always_comb begin
        op_legal = 1'b0;
        case (op)
            R_T, I_T, S_T, B_T, U_T, J_T, LW, JALR: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    end

    // States that own the memory port; derived from state only so the timeout has no loop
    assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // A ready on the WAIT_MAX-th stalled cycle still completes the access
    assign timeout = (WAIT_MAX != 0) && in_mem && !mem_ready && (wait_q == WW'(WAIT_MAX - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and Moore output decode; FETCH write enables are Mealy on mem_ready
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        mem_req_m   = 1'b0;
        mem_write_m = 1'b0;
        ir_write_m  = 1'b0;
        pc_write_m  = 1'b0;
        reg_write_m = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SA_PC;
        alu_src_b   = SB_B;
        alu_op      = ALU_ADD;
        imm_src     = IMM_I;
        result_src  = RS_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_req_m  = 1'b1;
                alu_src_b  = SB_FOUR;
                result_src = RS_ALU;
                if (mem_ready) begin
                    ir_write_m = 1'b1;
                    pc_write_m = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures oldPC + imm: the branch / JAL target
                alu_src_a = SA_OLDPC;
                alu_src_b = SB_IMM;
                imm_src   = imm_of(op);
                case (op)
                    LW, S_T: state_d = S_MEM_ADR;
                    R_T:     state_d = S_EXEC_R;
                    I_T:     state_d = S_EXEC_I;
                    B_T:     state_d = S_BRANCH;
                    J_T:     state_d = S_JAL;
                    JALR:    state_d = S_JALR;
                    U_T:     state_d = S_LUI;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SA_A;
                alu_src_b = SB_IMM;
                state_d   = (op == LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_m = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src  = RS_DATA;
                reg_write_m = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_m   = 1'b1;
                mem_write_m = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = SA_A;
                alu_op    = ALU_R;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = SA_A;
                alu_src_b = SB_IMM;
                alu_op    = ALU_I;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_m = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SA_A;
                alu_op     = ALU_BR;
                pc_write_m = taken;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SA_OLDPC;
                alu_src_b  = SB_FOUR;
                pc_write_m = 1'b1;
                state_d    = S_ALU_WB;
            end
            S_JALR: begin
                // Link is written first; the A register already holds rs1 for the target
                alu_src_a   = SA_OLDPC;
                alu_src_b   = SB_FOUR;
                result_src  = RS_ALU;
                reg_write_m = 1'b1;
                state_d     = S_JALR_PC;
            end
            S_JALR_PC: begin
                alu_src_a  = SA_A;
                alu_src_b  = SB_IMM;
                result_src = RS_ALU;
                pc_write_m = 1'b1;
                state_d    = S_FETCH;
            end
            S_LUI: begin
                imm_src     = IMM_U;
                result_src  = RS_IMM;
                reg_write_m = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (timeout) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
        end
    end

    // Wait counter restarts on every state change; instret counts real retirements only
    always_comb begin
        wait_d    = wait_q;
        instret_d = instret_q;
        if (state_d != state_q)        wait_d = '0;
        else if (in_mem && !mem_ready) wait_d = wait_q + WW'(1);
        if ((state_d == S_FETCH) && (state_q != S_FETCH) &&
            !((state_q == S_DECODE) && !op_legal))
            instret_d = instret_q + CNT_W'(1);
    end

    // Counter and sticky status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Strobes are gated by reset so an access or write dies the instant rst_n falls
    assign mem_req   = mem_req_m   & rst_n;
    assign mem_write = mem_write_m & rst_n;
    assign ir_write  = ir_write_m  & rst_n;
    assign pc_write  = pc_write_m  & rst_n;
    assign reg_write = reg_write_m & rst_n;

    assign illegal   = illegal_q;
    assign bus_err   = bus_err_q;
    assign halted    = (state_q == S_HALT);
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: two controllers (halt-on-illegal and NOP-on-illegal) fed identical stimulus.
// Latency: checks each FSM cycle one time unit after the rising edge.
// Backpressure: mem_ready is driven low on chosen cycles to exercise stalls and timeout.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] op        = 7'b0110011;
    logic [2:0] funct3    = 3'b000;
    logic       zero      = 1'b0;
    logic       lt        = 1'b0;
    logic       mem_ready = 1'b1;

    logic        mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0;
    logic [1:0]  alu_src_a0, alu_src_b0, alu_op0, result_src0;
    logic [2:0]  imm_src0;
    logic        illegal0, bus_err0, halted0;
    logic [31:0] instret0;

    logic        mem_req1, mem_write1, adr_src1, ir_write1, pc_write1, reg_write1;
    logic [1:0]  alu_src_a1, alu_src_b1, alu_op1, result_src1;
    logic [2:0]  imm_src1;
    logic        illegal1, bus_err1, halted1;
    logic [3:0]  instret1;

    logic [16:0] obs0;
    assign obs0 = {mem_req0, mem_write0, adr_src0, ir_write0, pc_write0, reg_write0,
                   alu_src_a0, alu_src_b0, alu_op0, imm_src0, result_src0};

    multicycle_controller #(.WAIT_MAX(4), .ILLEGAL_HALT(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .mem_req(mem_req0), .mem_write(mem_write0), .adr_src(adr_src0),
        .ir_write(ir_write0), .pc_write(pc_write0), .reg_write(reg_write0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0), .imm_src(imm_src0),
        .result_src(result_src0), .illegal(illegal0), .bus_err(bus_err0), .halted(halted0),
        .instret(instret0)
    );

    multicycle_controller #(.WAIT_MAX(4), .ILLEGAL_HALT(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .mem_req(mem_req1), .mem_write(mem_write1), .adr_src(adr_src1),
        .ir_write(ir_write1), .pc_write(pc_write1), .reg_write(reg_write1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1), .imm_src(imm_src1),
        .result_src(result_src1), .illegal(illegal1), .bus_err(bus_err1), .halted(halted1),
        .instret(instret1)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Expected output word: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, alu_op, imm, result}
    function automatic logic [16:0] ev(input logic mr, input logic mw, input logic as,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] ao, input logic [2:0] im,
                                       input logic [1:0] rs);
        return {mr, mw, as, irw, pcw, rw, a, b, ao, im, rs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [16:0] E_FETCH_RDY, E_FETCH_WAIT, E_EXEC_R, E_EXEC_I, E_ALU_WB, E_MEM_ADR;
    logic [16:0] E_MEM_RD, E_MEM_WB, E_MEM_WR, E_JAL, E_JALR, E_JALR_PC, E_LUI;
    logic [2:0]  bt_f3 [6];
    logic        bt_z  [6];
    logic        bt_lt [6];
    logic        bt_exp[6];

    initial begin
        E_FETCH_RDY  = ev(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10);
        E_FETCH_WAIT = ev(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10);
        E_EXEC_R     = ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00);
        E_EXEC_I     = ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b11, 3'b000, 2'b00);
        E_ALU_WB     = ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
        E_MEM_ADR    = ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00);
        E_MEM_RD     = ev(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
        E_MEM_WB     = ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01);
        E_MEM_WR     = ev(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00);
        E_JAL        = ev(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00);
        E_JALR       = ev(0, 0, 0, 0, 0, 1, 2'b01, 2'b10, 2'b00, 3'b000, 2'b10);
        E_JALR_PC    = ev(0, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b00, 3'b000, 2'b10);
        E_LUI        = ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b100, 2'b11);
        // funct3 / zero / lt -> taken
        bt_f3[0] = 3'b000; bt_z[0] = 1'b0; bt_lt[0] = 1'b0; bt_exp[0] = 1'b0;
        bt_f3[1] = 3'b001; bt_z[1] = 1'b0; bt_lt[1] = 1'b0; bt_exp[1] = 1'b1;
        bt_f3[2] = 3'b100; bt_z[2] = 1'b0; bt_lt[2] = 1'b1; bt_exp[2] = 1'b1;
        bt_f3[3] = 3'b101; bt_z[3] = 1'b0; bt_lt[3] = 1'b1; bt_exp[3] = 1'b0;
        bt_f3[4] = 3'b101; bt_z[4] = 1'b1; bt_lt[4] = 1'b0; bt_exp[4] = 1'b1;
        bt_f3[5] = 3'b010; bt_z[5] = 1'b1; bt_lt[5] = 1'b1; bt_exp[5] = 1'b0;

        // ---- reset ----
        #1 rst_n = 1'b0;
        #2;
        chk("rst.strobes", {27'd0, mem_req0, ir_write0, pc_write0, reg_write0, mem_write0}, 32'd0);
        chk("rst.flags", {29'd0, illegal0, bus_err0, halted0}, 32'd0);
        chk("rst.instret", instret0, 32'd0);
        #5;
        chk("rst.held_over_edge", {31'd0, mem_req0}, 32'd0);
        #4 rst_n = 1'b1;
        #1;
        // ---- add x3,x1,x2 ----
        chk("add.fetch", obs0, E_FETCH_RDY);
        step(); chk("add.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00));
        step(); chk("add.exec", obs0, E_EXEC_R);
        step(); chk("add.wb", obs0, E_ALU_WB);
        chk("add.instret_pre", instret0, 32'd0);
        step(); chk("add.ret", obs0, E_FETCH_RDY);
        chk("add.instret", instret0, 32'd1);
        // ---- lw with 3 wait cycles (ready lands on the WAIT_MAX-th cycle) ----
        op = LW;
        step(); chk("lw.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00));
        step(); chk("lw.adr", obs0, E_MEM_ADR);
        mem_ready = 1'b0;
        step(); chk("lw.rd1", obs0, E_MEM_RD);
        step(); chk("lw.rd2", obs0, E_MEM_RD);
        step(); chk("lw.rd3", obs0, E_MEM_RD);
        mem_ready = 1'b1;
        #1; chk("lw.rd4", obs0, E_MEM_RD);
        step(); chk("lw.wb", obs0, E_MEM_WB);
        chk("lw.no_buserr", {31'd0, bus_err0}, 32'd0);
        step(); chk("lw.ret", obs0, E_FETCH_RDY);
        chk("lw.instret", instret0, 32'd2);
        // ---- sw with one wait cycle ----
        op = S_T;
        step(); chk("sw.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b001, 2'b00));
        step(); chk("sw.adr", obs0, E_MEM_ADR);
        mem_ready = 1'b0;
        step(); chk("sw.wr1", obs0, E_MEM_WR);
        step(); chk("sw.wr2", obs0, E_MEM_WR);
        mem_ready = 1'b1;
        #1; chk("sw.wr2_rdy", obs0, E_MEM_WR);
        step(); chk("sw.ret", obs0, E_FETCH_RDY);
        chk("sw.instret", instret0, 32'd3);
        // ---- beq taken (zero=1) ----
        op = B_T; funct3 = 3'b000; zero = 1'b1;
        step(); chk("beq.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 2'b00));
        step(); chk("beq.branch", obs0, ev(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b01, 3'b000, 2'b00));
        step(); chk("beq.ret", obs0, E_FETCH_RDY);
        chk("beq.instret", instret0, 32'd4);
        // ---- bne not taken (zero=1), then sweep the branch condition table ----
        funct3 = 3'b001;
        step(); chk("bne.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b010, 2'b00));
        step(); chk("bne.branch", obs0, ev(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 3'b000, 2'b00));
        for (int i = 0; i < 6; i++) begin
            funct3 = bt_f3[i]; zero = bt_z[i]; lt = bt_lt[i];
            #1; chk($sformatf("br.cond%0d", i), {31'd0, pc_write0}, {31'd0, bt_exp[i]});
        end
        funct3 = 3'b000; zero = 1'b0; lt = 1'b0;
        step(); chk("bne.ret", obs0, E_FETCH_RDY);
        chk("bne.instret", instret0, 32'd5);
        // ---- jal ----
        op = J_T;
        step(); chk("jal.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b011, 2'b00));
        step(); chk("jal.jal", obs0, E_JAL);
        step(); chk("jal.wb", obs0, E_ALU_WB);
        step(); chk("jal.instret", instret0, 32'd6);
        // ---- jalr x1,0(x1) ----
        op = JALR;
        step(); chk("jalr.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000, 2'b00));
        step(); chk("jalr.link", obs0, E_JALR);
        step(); chk("jalr.pc", obs0, E_JALR_PC);
        step(); chk("jalr.ret", obs0, E_FETCH_RDY);
        chk("jalr.instret", instret0, 32'd7);
        // ---- lui ----
        op = U_T;
        step(); chk("lui.decode", obs0, ev(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b100, 2'b00));
        step(); chk("lui.lui", obs0, E_LUI);
        step(); chk("lui.instret", instret0, 32'd8);
        // ---- addi ----
        op = I_T;
        step(); step(); chk("addi.exec", obs0, E_EXEC_I);
        step(); chk("addi.wb", obs0, E_ALU_WB);
        step(); chk("addi.instret", instret0, 32'd9);
        // ---- fetch timeout: WAIT_MAX=4 stalled cycles ----
        mem_ready = 1'b0;
        #1; chk("to.w1", obs0, E_FETCH_WAIT);
        step(); chk("to.w2", obs0, E_FETCH_WAIT);
        step(); chk("to.w3", obs0, E_FETCH_WAIT);
        step(); chk("to.w4", obs0, E_FETCH_WAIT);
        chk("to.no_err_yet", {31'd0, bus_err0}, 32'd0);
        step(); chk("to.halt_strobes", obs0, 32'd0);
        chk("to.flags", {29'd0, illegal0, bus_err0, halted0}, 32'b011);
        chk("to.instret", instret0, 32'd9);
        chk("to.instret_narrow", {28'd0, instret1}, 32'd9);
        mem_ready = 1'b1;
        #1; chk("to.halt_ignores_ready", obs0, 32'd0);
        step(); chk("to.halt_stays", {31'd0, halted0}, 32'd1);
        chk("to.halt_quiet", obs0, 32'd0);
        // ---- reset pulse out of HALT ----
        rst_n = 1'b0;
        #1; chk("rp.strobes", obs0 & 17'h1F800, 32'd0);
        chk("rp.flags", {29'd0, illegal0, bus_err0, halted0}, 32'd0);
        chk("rp.instret", instret0, 32'd0);
        step();
        rst_n = 1'b1;
        #1; chk("rp.first_fetch", obs0, E_FETCH_RDY);
        // ---- reset asserted mid store ----
        op = S_T;
        step(); step();
        mem_ready = 1'b0;
        step(); chk("mid.pre", obs0, E_MEM_WR);
        rst_n = 1'b0;
        #1; chk("mid.drop", {30'd0, mem_req0, mem_write0}, 32'd0);
        step(); chk("mid.held", {27'd0, mem_req0, mem_write0, ir_write0, pc_write0, reg_write0}, 32'd0);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1; chk("mid.refetch", obs0, E_FETCH_RDY);
        chk("mid.instret", instret0, 32'd0);
        // ---- illegal opcode: halt policy vs NOP policy ----
        op = 7'b1111111;
        step(); step();
        chk("ill.halt_flags", {29'd0, illegal0, bus_err0, halted0}, 32'b101);
        chk("ill.halt_quiet", obs0, 32'd0);
        chk("ill.nop_flags", {29'd0, illegal1, bus_err1, halted1}, 32'b100);
        chk("ill.nop_refetch", {31'd0, mem_req1}, 32'd1);
        chk("ill.nop_instret", {28'd0, instret1}, 32'd0);
        op = U_T;
        step(); step(); step();
        chk("ill.nop_next_instret", {28'd0, instret1}, 32'd1);
        chk("ill.nop_sticky", {31'd0, illegal1}, 32'd1);
        chk("ill.halt_instret", instret0, 32'd0);
        // ---- instret wrap on the 4-bit counter ----
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 15; i++) begin
            step(); step(); step();
        end
        chk("wrap.pre", {28'd0, instret1}, 32'd15);
        step(); step(); step();
        chk("wrap.narrow", {28'd0, instret1}, 32'd0);
        chk("wrap.wide", instret0, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
